seven_seg_scan_ctrl: RTL and testbench

// Time-multiplexed scan controller for a multi-digit common-anode 7-segment display.

---
 rtl/seven_seg_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-aligned shadow word
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [4*NUM_DIGITS-1:0] wr_data,
  input  logic                    lzb_en,
  output logic [3:0]              digit_code,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [CW-1:0] CNT_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_DRIVE = 1'b1;

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [0:0]            r_state;
  logic [DW-1:0]         r_active;
  logic [DW-1:0]         r_pend;
  logic                  r_pend_full;
  logic                  r_lzb;
  logic [NUM_DIGITS-1:0] r_an_n;
  logic [3:0]            r_code;
  logic                  r_frame_done;

  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_accept;
  logic [CW-1:0]         w_cnt_nxt;
  logic [IW-1:0]         w_idx_nxt;
  logic [0:0]            w_state_nxt;
  logic [DW-1:0]         w_active_nxt;
  logic                  w_lzb_nxt;
  logic [NUM_DIGITS-1:0] w_lz;
  logic                  w_lz_run;
  logic                  w_lz_sel;
  logic [3:0]            w_code_sel;
  logic                  w_blank;
  logic [NUM_DIGITS-1:0] w_an_nxt;
  logic                  w_frame_done_nxt;

  assign w_slot_end  = (r_cnt == CNT_LAST);
  assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
  assign w_accept    = wr_valid && !r_pend_full;
  assign wr_ready    = ~r_pend_full;

  // Next slot position, FSM state, displayed word and blanking mode
  always_comb begin
    w_cnt_nxt = w_slot_end ? '0 : r_cnt + CW'(1);
    w_idx_nxt = r_idx;
    if (w_slot_end) begin
      w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
    end
    w_state_nxt = r_state;
    if (r_state == ST_BLANK) begin
      if (r_cnt == BLANK_LAST) w_state_nxt = ST_DRIVE;
    end else begin
      if (w_slot_end) w_state_nxt = ST_BLANK;
    end
    // New word only lands at the frame wrap; an empty pending slot lets a
    // same-cycle write bypass straight into the active word.
    w_active_nxt = r_active;
    if (w_frame_end) begin
      if (r_pend_full) w_active_nxt = r_pend;
      else if (w_accept) w_active_nxt = wr_data;
    end
    w_lzb_nxt = w_slot_end ? lzb_en : r_lzb;
  end

  // Decode the next cycle's outputs from the next-state values so outputs stay registered
  always_comb begin
    w_lz_run   = 1'b1;
    w_lz       = '0;
    w_lz_sel   = 1'b0;
    w_code_sel = 4'hF;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_lz_run = w_lz_run && (w_active_nxt[4*k +: 4] == 4'h0);
      w_lz[k]  = w_lz_run;
    end
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_idx_nxt == IW'(k)) begin
        w_code_sel = w_active_nxt[4*k +: 4];
        w_lz_sel   = w_lz[k];
      end
    end
    w_blank = w_lzb_nxt && (w_idx_nxt != '0) && w_lz_sel;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_an_nxt[k] = !((w_state_nxt == ST_DRIVE) && !w_blank && (w_idx_nxt == IW'(k)));
    end
    w_frame_done_nxt = (w_cnt_nxt == CNT_LAST) && (w_idx_nxt == IDX_LAST);
  end

  // Slot counter, digit index, scan state and slot-sampled blanking mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_state <= ST_BLANK;
      r_lzb   <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_state <= w_state_nxt;
      r_lzb   <= w_lzb_nxt;
    end
  end

  // Host word path: pending shadow register and frame-aligned active word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= {DW{1'b1}};
      r_pend      <= '0;
      r_pend_full <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      if (w_frame_end && r_pend_full) begin
        r_pend_full <= 1'b0;
      end else if (w_accept && !w_frame_end) begin
        r_pend      <= wr_data;
        r_pend_full <= 1'b1;
      end
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_an_n       <= {NUM_DIGITS{1'b1}};
      r_code       <= 4'hF;
      r_frame_done <= 1'b0;
    end else begin
      r_an_n       <= w_an_nxt;
      r_code       <= w_blank ? 4'hF : w_code_sel;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  assign an_n       = r_an_n;
  assign digit_code = r_code;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl
module tb_seven_seg_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [15:0] wr_data;
  logic        lzb_en;
  logic [3:0]  digit_code;
  logic [3:0]  an_n;
  logic        frame_done;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS  (4),
    .PRESCALE    (8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .lzb_en    (lzb_en),
    .digit_code(digit_code),
    .an_n      (an_n),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic        lzb;
    logic [15:0] codes;
    logic [3:0]  lit;
  } vec_t;

  vec_t vecs[8];

  int n_chk;
  int n_err;
  int t;

  logic [15:0] m_active;
  logic [15:0] m_pend;
  logic        m_full;
  logic        m_lzb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, t);
    end
  endtask

  // One clock: compare outputs with the reference, apply the edge to the reference, advance.
  task automatic cyc();
    int idx;
    int pos;
    logic blanked;
    logic [3:0] ea;
    logic [3:0] ec;
    logic acc;
    idx = (t / 8) % 4;
    pos = t % 8;
    blanked = m_lzb && (idx != 0) && ((m_active >> (4 * idx)) == 16'h0);
    ec = blanked ? 4'hF : 4'((m_active >> (4 * idx)) & 16'hF);
    ea = 4'hF;
    if (pos >= 2 && !blanked) ea[idx] = 1'b0;
    chk("model_an_n", an_n, ea);
    chk("model_digit_code", digit_code, ec);
    chk("model_frame_done", frame_done, (t % 32) == 31);
    chk("model_wr_ready", wr_ready, !m_full);
    acc = wr_valid && !m_full;
    if ((t % 32) == 31) begin
      if (m_full) begin
        m_active = m_pend;
        m_full   = 1'b0;
      end else if (acc) begin
        m_active = wr_data;
      end
    end else if (acc) begin
      m_pend = wr_data;
      m_full = 1'b1;
    end
    if (pos == 7) m_lzb = lzb_en;
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic do_reset();
    #2;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    #1;
    chk("rst_async_an_n", an_n, 4'hF);
    chk("rst_async_code", digit_code, 4'hF);
    chk("rst_async_frame_done", frame_done, 1'b0);
    chk("rst_async_wr_ready", wr_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    t        = 0;
    m_active = 16'hFFFF;
    m_pend   = 16'h0;
    m_full   = 1'b0;
    m_lzb    = 1'b0;
  endtask

  task automatic write_word(input logic [15:0] d);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    wr_valid = 1'b1;
    wr_data  = d;
    while (!acc && n < 100) begin
      acc = !m_full;
      cyc();
      n++;
    end
    wr_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_err++;
      $display("FAIL write_timeout: word %0h not accepted within %0d cycles", d, n);
    end
  endtask

  // Advance to a frame start, then check the first drive cycle of every slot.
  task automatic check_frame(input logic [15:0] codes, input logic [3:0] lit, input string nm);
    int guard;
    logic [3:0] ea;
    guard = 0;
    while ((t % 32) != 0 && guard < 64) begin
      cyc();
      guard++;
    end
    for (int d = 0; d < 4; d++) begin
      guard = 0;
      while (!((t % 8) == 2 && ((t / 8) % 4) == d) && guard < 40) begin
        cyc();
        guard++;
      end
      ea = 4'hF;
      if (lit[d]) ea[d] = 1'b0;
      chk($sformatf("%s_an_n_d%0d", nm, d), an_n, ea);
      chk($sformatf("%s_code_d%0d", nm, d), digit_code, codes[4*d +: 4]);
    end
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'h0;
    for (int k = 0; k < 4; k++) begin
      if ($urandom_range(0, 1) == 1) w[4*k +: 4] = 4'($urandom_range(0, 15));
    end
    return w;
  endfunction

  initial begin
    int first_fd;
    int second_fd;
    int n;
    logic acc;

    vecs[0] = '{16'h1234, 1'b0, 16'h1234, 4'b1111};
    vecs[1] = '{16'h0050, 1'b1, 16'hFF50, 4'b0011};
    vecs[2] = '{16'h0000, 1'b1, 16'hFFF0, 4'b0001};
    vecs[3] = '{16'h0000, 1'b0, 16'h0000, 4'b1111};
    vecs[4] = '{16'h0A00, 1'b1, 16'hFA00, 4'b0111};
    vecs[5] = '{16'h1000, 1'b1, 16'h1000, 4'b1111};
    vecs[6] = '{16'hBCDE, 1'b0, 16'hBCDE, 4'b1111};
    vecs[7] = '{16'hF0F0, 1'b1, 16'hF0F0, 4'b1111};

    n_chk    = 0;
    n_err    = 0;
    t        = 0;
    clk      = 1'b0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = 16'h0;
    lzb_en   = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Reset release and scan timing
    chk("t1_an_n_c0", an_n, 4'hF);
    chk("t1_code_c0", digit_code, 4'hF);
    chk("t1_ready_c0", wr_ready, 1'b1);
    cyc();
    chk("t1_an_n_c1", an_n, 4'hF);
    cyc();
    chk("t1_an_n_c2", an_n, 4'b1110);
    first_fd  = -1;
    second_fd = -1;
    while (t < 70) begin
      if (frame_done) begin
        if (first_fd < 0) first_fd = t;
        else if (second_fd < 0) second_fd = t;
      end
      cyc();
    end
    chk("t1_first_frame_done", first_fd, 31);
    chk("t1_second_frame_done", second_fd, 63);

    // Plain write mid-frame
    write_word(16'h1234);
    chk("t2_ready_low", wr_ready, 1'b0);
    check_frame(16'h1234, 4'b1111, "t2");
    chk("t2_ready_back", wr_ready, 1'b1);

    // Second write held off until the boundary frees the pending slot
    while ((t % 32) != 0) cyc();
    write_word(16'h1234);
    wr_valid = 1'b1;
    wr_data  = 16'h5678;
    n = 0;
    while (m_full && n < 64) begin
      chk("t3_held_ready", wr_ready, 1'b0);
      cyc();
      n++;
    end
    chk("t3_accept_cycle", t % 32, 0);
    chk("t3_accept_ready", wr_ready, 1'b1);
    cyc();
    wr_valid = 1'b0;
    chk("t3_old_word_d0", digit_code, 4'h4);
    check_frame(16'h5678, 4'b1111, "t3");

    // Table of words and blanking modes
    for (int i = 0; i < 8; i++) begin
      lzb_en = vecs[i].lzb;
      write_word(vecs[i].data);
      check_frame(vecs[i].codes, vecs[i].lit, $sformatf("t4_v%0d", i));
    end

    // Write landing exactly on the frame_done cycle bypasses the shadow
    lzb_en = 1'b0;
    while ((t % 32) != 31) cyc();
    wr_valid = 1'b1;
    wr_data  = 16'h9ABC;
    cyc();
    wr_valid = 1'b0;
    chk("t5_ready_stays", wr_ready, 1'b1);
    check_frame(16'h9ABC, 4'b1111, "t5");

    // Asynchronous reset mid-drive discards the pending word
    while ((t % 32) != 5) cyc();
    write_word(16'h4321);
    while ((t % 32) != 11) cyc();
    chk("t6_pre_reset_an_n", an_n, 4'b1101);
    do_reset();
    check_frame(16'hFFFF, 4'b1111, "t6_f0");
    check_frame(16'hFFFF, 4'b1111, "t6_f1");

    // Randomised traffic against the reference
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 49) == 0) lzb_en = ~lzb_en;
      if (!wr_valid && $urandom_range(0, 5) == 0) begin
        wr_valid = 1'b1;
        wr_data  = rand_word();
      end
      acc = wr_valid && !m_full;
      cyc();
      if (acc) wr_valid = 1'b0;
      if (i == 1000) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
